// File: rtl/clkdiv_pkg.sv
// Shared constants for the multi-channel clock divider.
// Channel output modes and the power-on divisor live here.
package clkdiv_pkg;

    localparam int CNT_W = 28;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    localparam logic [CNT_W-1:0] DEFAULT_DIV = 28'd100000000;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, shadowed divisor and registered tick/out.
// Divisor loads while running are held pending until the next wrap.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int               W        = CNT_W,
    parameter logic [W-1:0]     INIT_DIV = W'(DEFAULT_DIV)
) (
    input  logic         clk_in,
    input  logic         reset_in,
    input  logic [W-1:0] div_val,
    input  logic         load,
    input  logic         en,
    input  logic         mode,
    input  logic         resync,
    output logic         tick,
    output logic         out
);

    logic [W-1:0] count;
    logic [W-1:0] active_div;
    logic [W-1:0] pending_div;
    logic         pend_valid;
    logic         running;
    logic         terminal;

    // A zero divisor is treated as disabled before the terminal compare.
    assign running  = en && (active_div != '0);
    assign terminal = (count == active_div - {{(W-1){1'b0}}, 1'b1});

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            count       <= '0;
            active_div  <= INIT_DIV;
            pending_div <= '0;
            pend_valid  <= 1'b0;
            tick        <= 1'b0;
            out         <= 1'b0;
        end else if (resync) begin
            count      <= '0;
            tick       <= 1'b0;
            out        <= 1'b0;
            pend_valid <= 1'b0;
            if (load) begin
                active_div <= div_val;
            end else if (pend_valid) begin
                active_div <= pending_div;
            end
        end else if (running) begin
            if (terminal) begin
                count      <= '0;
                tick       <= 1'b1;
                out        <= (mode == MODE_PULSE) ? 1'b1 : ~out;
                pend_valid <= 1'b0;
                // A load landing on the wrap edge beats any older pending value.
                if (load) begin
                    active_div <= div_val;
                end else if (pend_valid) begin
                    active_div <= pending_div;
                end
            end else begin
                count <= count + {{(W-1){1'b0}}, 1'b1};
                tick  <= 1'b0;
                if (mode == MODE_PULSE) begin
                    out <= 1'b0;
                end
                if (load) begin
                    pending_div <= div_val;
                    pend_valid  <= 1'b1;
                end
            end
        end else begin
            count <= '0;
            tick  <= 1'b0;
            if (mode == MODE_PULSE) begin
                out <= 1'b0;
            end
            if (load) begin
                active_div <= div_val;
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_clkdiv.sv
// Multi-channel clock divider / strobe generator for game timing.
// Slices the packed divisor bus and fans resync out to every channel.
module multi_clkdiv
    import clkdiv_pkg::*;
#(
    parameter int                 NUM_CH      = 4,
    parameter int                 CNT_W       = clkdiv_pkg::CNT_W,
    parameter logic [CNT_W-1:0]   DEFAULT_DIV = CNT_W'(clkdiv_pkg::DEFAULT_DIV)
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic [NUM_CH*CNT_W-1:0]   div_val_in,
    input  logic [NUM_CH-1:0]         load_in,
    input  logic [NUM_CH-1:0]         en_in,
    input  logic [NUM_CH-1:0]         mode_in,
    input  logic                      resync_in,
    output logic [NUM_CH-1:0]         tick_out,
    output logic [NUM_CH-1:0]         clk_out
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clkdiv_channel #(
            .W        (CNT_W),
            .INIT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_in   (clk_in),
            .reset_in (reset_in),
            .div_val  (div_val_in[i*CNT_W +: CNT_W]),
            .load     (load_in[i]),
            .en       (en_in[i]),
            .mode     (mode_in[i]),
            .resync   (resync_in),
            .tick     (tick_out[i]),
            .out      (clk_out[i])
        );
    end

endmodule

// File: tb/tb_multi_clkdiv.sv
// Directed bench for multi_clkdiv with hand-computed tick/clk_out histories.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_multi_clkdiv;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 28;

    logic                    clk_in;
    logic                    reset_in;
    logic [NUM_CH*CNT_W-1:0] div_val_in;
    logic [NUM_CH-1:0]       load_in;
    logic [NUM_CH-1:0]       en_in;
    logic [NUM_CH-1:0]       mode_in;
    logic                    resync_in;
    logic [NUM_CH-1:0]       tick_out;
    logic [NUM_CH-1:0]       clk_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] tk_h [NUM_CH];
    logic [31:0] ck_h [NUM_CH];

    multi_clkdiv #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .div_val_in (div_val_in),
        .load_in    (load_in),
        .en_in      (en_in),
        .mode_in    (mode_in),
        .resync_in  (resync_in),
        .tick_out   (tick_out),
        .clk_out    (clk_out)
    );

    // clock
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_div(input int ch, input logic [CNT_W-1:0] v);
        div_val_in[ch*CNT_W +: CNT_W] = v;
    endtask

    // Load a divisor into a disabled channel (applied directly at the edge).
    task automatic load_now(input int ch, input logic [CNT_W-1:0] v);
        set_div(ch, v);
        load_in[ch] = 1'b1;
        step();
        load_in[ch] = 1'b0;
    endtask

    // Bit k of each history = output sampled after step k+1.
    task automatic rec(input int n);
        for (int c = 0; c < NUM_CH; c++) begin
            tk_h[c] = '0;
            ck_h[c] = '0;
        end
        for (int k = 0; k < n; k++) begin
            step();
            for (int c = 0; c < NUM_CH; c++) begin
                tk_h[c][k] = tick_out[c];
                ck_h[c][k] = clk_out[c];
            end
        end
    endtask

    initial begin
        reset_in   = 1'b1;
        div_val_in = '0;
        load_in    = '0;
        en_in      = '0;
        mode_in    = '0;
        resync_in  = 1'b0;
        step();
        step();
        check("reset_tick", 32'(tick_out), 32'h0);
        check("reset_clk",  32'(clk_out),  32'h0);
        reset_in = 1'b0;
        step();

        // ch0: divisor 4, toggle mode
        load_now(0, 28'd4);
        en_in[0] = 1'b1;
        rec(16);
        check("ch0_div4_tick", tk_h[0] & 32'hFFFF, 32'h8888);
        check("ch0_div4_clk",  ck_h[0] & 32'hFFFF, 32'h7878);
        en_in[0] = 1'b0;

        // ch1: divisor 5, reload 2 at count=1 -> 5-cycle period then 2
        load_now(1, 28'd5);
        en_in[1] = 1'b1;
        tk_h[1] = '0;
        for (int k = 0; k < 12; k++) begin
            if (k == 1) begin
                set_div(1, 28'd2);
                load_in[1] = 1'b1;
            end
            step();
            load_in[1] = 1'b0;
            tk_h[1][k] = tick_out[1];
        end
        check("ch1_reload_tick", tk_h[1], 32'h550);
        en_in[1] = 1'b0;

        // ch2: divisor 1 in pulse mode, then toggle mode
        load_now(2, 28'd1);
        mode_in[2] = 1'b1;
        en_in[2]   = 1'b1;
        rec(4);
        check("ch2_pulse_tick", tk_h[2] & 32'hF, 32'hF);
        check("ch2_pulse_clk",  ck_h[2] & 32'hF, 32'hF);
        mode_in[2] = 1'b0;
        rec(4);
        check("ch2_toggle_tick", tk_h[2] & 32'hF, 32'hF);
        check("ch2_toggle_clk",  ck_h[2] & 32'hF, 32'hA);
        en_in[2] = 1'b0;

        // ch3: divisor 0 never ticks, then divisor 3
        load_now(3, 28'd0);
        en_in[3] = 1'b1;
        rec(8);
        check("ch3_div0_tick", tk_h[3] & 32'hFF, 32'h0);
        check("ch3_div0_clk",  ck_h[3] & 32'hFF, 32'h0);
        en_in[3] = 1'b0;
        load_now(3, 28'd3);
        en_in[3] = 1'b1;
        rec(9);
        check("ch3_div3_tick", tk_h[3] & 32'h1FF, 32'h124);
        check("ch3_div3_clk",  ck_h[3] & 32'h1FF, 32'h11C);
        en_in[3] = 1'b0;

        // ch0 at 4 and ch1 at 2 run out of phase; ch1 gets pending 7,
        // ch0 gets 3 simultaneously with resync.
        en_in[1:0] = 2'b11;
        step();
        step();
        step();
        set_div(1, 28'd7);
        load_in[1] = 1'b1;
        step();
        load_in[1] = 1'b0;
        step();
        set_div(0, 28'd3);
        load_in[0] = 1'b1;
        resync_in  = 1'b1;
        step();
        load_in[0] = 1'b0;
        resync_in  = 1'b0;
        check("resync_tick", 32'(tick_out), 32'h0);
        check("resync_clk",  32'(clk_out),  32'h0);
        rec(7);
        check("resync_ch0_tick", tk_h[0] & 32'h7F, 32'h24);
        check("resync_ch0_clk",  ck_h[0] & 32'h7F, 32'h1C);
        check("resync_ch1_tick", tk_h[1] & 32'h7F, 32'h40);
        check("resync_ch1_clk",  ck_h[1] & 32'h7F, 32'h40);

        // async reset mid-period with a pending load on ch0
        step();
        step();
        check("pre_reset_clk0", 32'(clk_out[0]), 32'h1);
        set_div(0, 28'd2);
        load_in[0] = 1'b1;
        step();
        load_in[0] = 1'b0;
        #3;
        reset_in = 1'b1;
        #1;
        check("async_reset_tick", 32'(tick_out), 32'h0);
        check("async_reset_clk",  32'(clk_out),  32'h0);
        step();
        reset_in = 1'b0;
        resync_in = 1'b1;
        step();
        resync_in = 1'b0;
        rec(10);
        check("post_reset_ch0_tick", tk_h[0] & 32'h3FF, 32'h0);
        check("post_reset_ch1_tick", tk_h[1] & 32'h3FF, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
